// File: rtl/composite_router_pkg.sv
// Shared types and constants for the composite packet router.
package composite_router_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DROP = 2'd2
    } router_state_t;

    localparam int DROP_CNT_W = 16;

    // One extra bit beyond the channel index so out-of-range destinations are representable.
    function automatic int dest_w(input int num_out);
        return $clog2(num_out) + 1;
    endfunction

endpackage

// File: rtl/composite_router_n_fifo.sv
// Small synchronous FIFO used as the router meta queue; a push into a full queue is refused.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/composite_router_n.sv
// Meta-steered packet router: each queued meta word routes the next data packet to one channel.
// state | meaning
// IDLE  | waiting for a queued meta word; input data stalled
// SEND  | meta offered on channel d, data passed through until last beat
// DROP  | destination out of range; beats consumed and discarded
module composite_router_n
    import composite_router_pkg::*;
#(
    parameter int NUM_OUT    = 4,
    parameter int DATA_W     = 32,
    parameter int META_W     = 8,
    parameter int META_DEPTH = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            io_in_meta_valid,
    output logic                            io_in_meta_ready,
    input  logic [META_W-1:0]               io_in_meta_bits,
    input  logic                            io_in_data_valid,
    output logic                            io_in_data_ready,
    input  logic [DATA_W-1:0]               io_in_data_bits_data,
    input  logic [DATA_W/8-1:0]             io_in_data_bits_keep,
    input  logic                            io_in_data_bits_last,
    output logic [NUM_OUT-1:0]              io_out_meta_valid,
    input  logic [NUM_OUT-1:0]              io_out_meta_ready,
    output logic [NUM_OUT*META_W-1:0]       io_out_meta_bits,
    output logic [NUM_OUT-1:0]              io_out_data_valid,
    input  logic [NUM_OUT-1:0]              io_out_data_ready,
    output logic [NUM_OUT*DATA_W-1:0]       io_out_data_bits_data,
    output logic [NUM_OUT*(DATA_W/8)-1:0]   io_out_data_bits_keep,
    output logic [NUM_OUT-1:0]              io_out_data_bits_last,
    output logic [DROP_CNT_W-1:0]           io_drop_count
);
    localparam int DEST_W = dest_w(NUM_OUT);
    localparam logic [DEST_W-1:0] NUM_OUT_D = DEST_W'(NUM_OUT);

    router_state_t         state;
    router_state_t         state_d;
    logic [META_W-1:0]     head;
    logic [META_W-1:0]     meta_q;
    logic [DEST_W-1:0]     dest_q;
    logic                  full;
    logic                  empty;
    logic                  pop;
    logic                  meta_done;
    logic                  data_done;
    logic                  meta_fire;
    logic                  last_fire;
    logic                  drop_last;
    logic [NUM_OUT-1:0]    sel;
    logic [DROP_CNT_W-1:0] drop_cnt;

    sync_fifo #(
        .WIDTH (META_W),
        .DEPTH (META_DEPTH)
    ) u_meta_q (
        .clock     (clock),
        .reset     (reset),
        .push      (io_in_meta_valid),
        .push_data (io_in_meta_bits),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_OUT; i++) sel[i] = (dest_q == DEST_W'(i));
    end

    always_comb begin
        state_d           = state;
        pop               = 1'b0;
        io_out_meta_valid = '0;
        io_out_data_valid = '0;
        io_in_data_ready  = 1'b0;
        meta_fire         = 1'b0;
        last_fire         = 1'b0;
        drop_last         = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = (head[DEST_W-1:0] < NUM_OUT_D) ? SEND : DROP;
                end
            end
            SEND: begin
                if (!meta_done) io_out_meta_valid = sel;
                if (!data_done) begin
                    io_out_data_valid = sel & {NUM_OUT{io_in_data_valid}};
                    io_in_data_ready  = |(sel & io_out_data_ready);
                end
                meta_fire = |(io_out_meta_valid & io_out_meta_ready);
                last_fire = io_in_data_valid && io_in_data_ready && io_in_data_bits_last;
                if ((meta_done || meta_fire) && (data_done || last_fire)) state_d = IDLE;
            end
            DROP: begin
                io_in_data_ready = 1'b1;
                drop_last        = io_in_data_valid && io_in_data_bits_last;
                if (drop_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            meta_q    <= '0;
            dest_q    <= '0;
            meta_done <= 1'b0;
            data_done <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            state <= state_d;
            if (pop) begin
                meta_q    <= head;
                dest_q    <= head[DEST_W-1:0];
                meta_done <= 1'b0;
                data_done <= 1'b0;
            end
            if (meta_fire) meta_done <= 1'b1;
            if (last_fire) data_done <= 1'b1;
            if (drop_last && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end

    // Queue must look full while held in reset so nothing is pushed.
    assign io_in_meta_ready      = !full && !reset;
    assign io_out_meta_bits      = {NUM_OUT{meta_q}};
    assign io_out_data_bits_data = {NUM_OUT{io_in_data_bits_data}};
    assign io_out_data_bits_keep = {NUM_OUT{io_in_data_bits_keep}};
    assign io_out_data_bits_last = {NUM_OUT{io_in_data_bits_last}};
    assign io_drop_count         = drop_cnt;

endmodule

// File: tb/tb_composite_router_n.sv
// Directed self-checking bench for composite_router_n (4 channels, 32-bit data, 8-bit meta).
module tb_composite_router_n;

    logic         clock;
    logic         reset;
    logic         in_meta_valid;
    logic         io_in_meta_ready;
    logic [7:0]   in_meta_bits;
    logic         in_data_valid;
    logic         io_in_data_ready;
    logic [31:0]  in_data;
    logic [3:0]   in_keep;
    logic         in_last;
    logic [3:0]   io_out_meta_valid;
    logic [3:0]   out_meta_ready;
    logic [31:0]  io_out_meta_bits;
    logic [3:0]   io_out_data_valid;
    logic [3:0]   out_data_ready;
    logic [127:0] io_out_data_bits_data;
    logic [15:0]  io_out_data_bits_keep;
    logic [3:0]   io_out_data_bits_last;
    logic [15:0]  io_drop_count;

    int errors = 0;
    int checks = 0;
    int out_fires = 0;

    composite_router_n #(
        .NUM_OUT    (4),
        .DATA_W     (32),
        .META_W     (8),
        .META_DEPTH (4)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .io_in_meta_valid      (in_meta_valid),
        .io_in_meta_ready      (io_in_meta_ready),
        .io_in_meta_bits       (in_meta_bits),
        .io_in_data_valid      (in_data_valid),
        .io_in_data_ready      (io_in_data_ready),
        .io_in_data_bits_data  (in_data),
        .io_in_data_bits_keep  (in_keep),
        .io_in_data_bits_last  (in_last),
        .io_out_meta_valid     (io_out_meta_valid),
        .io_out_meta_ready     (out_meta_ready),
        .io_out_meta_bits      (io_out_meta_bits),
        .io_out_data_valid     (io_out_data_valid),
        .io_out_data_ready     (out_data_ready),
        .io_out_data_bits_data (io_out_data_bits_data),
        .io_out_data_bits_keep (io_out_data_bits_keep),
        .io_out_data_bits_last (io_out_data_bits_last),
        .io_drop_count         (io_drop_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) begin
        if (!reset) out_fires <= out_fires + $countones(io_out_data_valid & out_data_ready);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic meta_in(input logic [7:0] m);
        int n = 0;
        in_meta_valid = 1'b1;
        in_meta_bits  = m;
        #1;
        while (!io_in_meta_ready && n < 50) begin @(negedge clock); #1; n++; end
        chk("meta_in_timeout", n < 50, 1);
        @(negedge clock);
        in_meta_valid = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic l, input int ch);
        int n = 0;
        logic [3:0] oh;
        in_data_valid = 1'b1;
        in_data       = d;
        in_last       = l;
        in_keep       = 4'hF;
        #1;
        while (!io_in_data_ready && n < 50) begin @(negedge clock); #1; n++; end
        chk("beat_timeout", n < 50, 1);
        if (ch >= 0) begin
            oh = 4'(1 << ch);
            chk("beat_valid", io_out_data_valid, oh);
            chk("beat_data", io_out_data_bits_data[ch*32 +: 32], d);
            chk("beat_keep", io_out_data_bits_keep[ch*4 +: 4], 4'hF);
            chk("beat_last", io_out_data_bits_last[ch], l);
        end else begin
            chk("drop_data_valid", io_out_data_valid, 0);
            chk("drop_meta_valid", io_out_meta_valid, 0);
        end
        @(negedge clock);
        in_data_valid = 1'b0;
    endtask

    task automatic meta_out(input int ch, input logic [7:0] m);
        int n = 0;
        logic [3:0] oh;
        oh = 4'(1 << ch);
        #1;
        while (io_out_meta_valid == 4'b0 && n < 50) begin @(negedge clock); #1; n++; end
        chk("meta_out_timeout", n < 50, 1);
        chk("meta_out_valid", io_out_meta_valid, oh);
        chk("meta_out_bits", io_out_meta_bits[ch*8 +: 8], m);
        out_meta_ready = oh;
        @(negedge clock);
        out_meta_ready = 4'b0;
    endtask

    initial begin
        reset          = 1'b1;
        in_meta_valid  = 1'b0;
        in_meta_bits   = 8'h0;
        in_data_valid  = 1'b0;
        in_data        = 32'h0;
        in_keep        = 4'h0;
        in_last        = 1'b0;
        out_meta_ready = 4'b0;
        out_data_ready = 4'hF;

        // reset values
        repeat (2) @(negedge clock);
        #1;
        chk("rst_meta_ready", io_in_meta_ready, 0);
        chk("rst_data_ready", io_in_data_ready, 0);
        chk("rst_meta_valid", io_out_meta_valid, 0);
        chk("rst_data_valid", io_out_data_valid, 0);
        chk("rst_drop_count", io_drop_count, 0);
        chk("rst_meta_bits", io_out_meta_bits, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_meta_ready", io_in_meta_ready, 1);

        // basic routing, first packet latency t+2
        meta_in(8'h00);
        #1;
        chk("lat_t1_meta_valid", io_out_meta_valid, 0);
        meta_in(8'h01);
        #1;
        chk("lat_t2_meta_valid", io_out_meta_valid, 4'b0001);
        meta_in(8'h02);
        meta_in(8'h03);
        for (int k = 0; k < 4; k++) begin
            beat(32'(k), 1'b1, k);
            meta_out(k, 8'(k));
        end
        for (int k = 4; k < 8; k++) meta_in(8'(k - 4));
        for (int k = 4; k < 8; k++) begin
            beat(32'(k), 1'b1, k - 4);
            meta_out(k - 4, 8'(k - 4));
        end
        chk("basic_drop_count", io_drop_count, 0);

        // multi-beat routing with one idle bubble between packets
        for (int c = 0; c < 4; c++) meta_in(8'h40 + 8'(c));
        for (int c = 0; c < 4; c++) begin
            beat(32'h100 * 32'(c) + 32'h1, 1'b0, c);
            beat(32'h100 * 32'(c) + 32'h2, 1'b0, c);
            beat(32'h100 * 32'(c) + 32'h3, 1'b1, c);
            meta_out(c, 8'h40 + 8'(c));
            #1;
            chk("bubble_data_ready", io_in_data_ready, 0);
            chk("bubble_meta_valid", io_out_meta_valid, 0);
        end

        // meta early: queue fills while first packet waits for data
        meta_in(8'hA0);
        meta_in(8'hA1);
        meta_in(8'hA2);
        meta_in(8'hA3);
        meta_in(8'hA0);
        #1;
        chk("queue_full_ready", io_in_meta_ready, 0);
        repeat (10) @(negedge clock);
        #1;
        chk("queue_full_hold", io_in_meta_ready, 0);
        beat(32'hC8, 1'b1, 0);
        meta_out(0, 8'hA0);
        #1;
        chk("full_pop_refuse", io_in_meta_ready, 0);
        beat(32'hC9, 1'b1, 1);
        meta_out(1, 8'hA1);
        beat(32'hCA, 1'b1, 2);
        meta_out(2, 8'hA2);
        beat(32'hCB, 1'b1, 3);
        meta_out(3, 8'hA3);
        beat(32'hCC, 1'b1, 0);
        meta_out(0, 8'hA0);

        // data early: stalls with no loss until meta arrives
        in_data_valid = 1'b1;
        in_data       = 32'hD0;
        in_last       = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        chk("early_data_ready", io_in_data_ready, 0);
        chk("early_data_valid", io_out_data_valid, 0);
        chk("early_meta_valid", io_out_meta_valid, 0);
        meta_in(8'h02);
        beat(32'hD0, 1'b0, 2);
        beat(32'hD1, 1'b1, 2);
        meta_out(2, 8'h02);

        // drop an out-of-range destination, then route normally
        meta_in(8'h07);
        meta_in(8'h01);
        beat(32'hE0, 1'b0, -1);
        beat(32'hE1, 1'b0, -1);
        beat(32'hE2, 1'b1, -1);
        chk("drop_count_one", io_drop_count, 1);
        beat(32'hE3, 1'b1, 1);
        meta_out(1, 8'h01);

        // backpressure on channel 2 mid-packet
        meta_in(8'h02);
        beat(32'hB0, 1'b0, 2);
        out_data_ready = 4'b1011;
        in_data_valid  = 1'b1;
        in_data        = 32'hB1;
        in_last        = 1'b0;
        #1;
        chk("stall_data_ready", io_in_data_ready, 0);
        chk("stall_data_valid", io_out_data_valid, 4'b0100);
        repeat (2) @(negedge clock);
        #1;
        chk("stall_hold_ready", io_in_data_ready, 0);
        chk("stall_hold_data", io_out_data_bits_data[64 +: 32], 32'hB1);
        out_data_ready = 4'hF;
        beat(32'hB1, 1'b0, 2);
        beat(32'hB2, 1'b1, 2);
        meta_out(2, 8'h02);

        // reset mid-packet
        meta_in(8'h03);
        beat(32'hF0, 1'b0, 3);
        in_data_valid = 1'b1;
        in_data       = 32'hF1;
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_meta_valid", io_out_meta_valid, 0);
        chk("midrst_data_valid", io_out_data_valid, 0);
        chk("midrst_data_ready", io_in_data_ready, 0);
        chk("midrst_meta_ready", io_in_meta_ready, 0);
        chk("midrst_drop_count", io_drop_count, 0);
        chk("midrst_meta_bits", io_out_meta_bits, 0);
        @(negedge clock);
        reset         = 1'b0;
        in_data_valid = 1'b0;
        #1;
        chk("after_rst_meta_ready", io_in_meta_ready, 1);
        chk("after_rst_meta_valid", io_out_meta_valid, 0);

        // 8 basic + 12 multi + 5 early-meta + 2 early-data + 1 drop-test + 3 backpressure + 1 pre-reset
        chk("total_out_beats", out_fires, 32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
